ht_decoder: RTL and testbench



---
 rtl/ht_decoder.sv | 171 +++++++++++++++++
 tb/tb_ht_decoder.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ht_decoder.sv
// ht_decoder: rebuilds the Huffman tree from 8 character weights,
// then walks it with a serial code-bit stream, NUM_CHAR chars per frame.
module ht_decoder #(
  parameter int NUM_CHAR = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [2:0] in_weight,
  input  logic       code_valid,
  input  logic       code_in,
  output logic       ready,
  output logic       out_valid,
  output logic [2:0] out_char
);

  typedef enum logic [1:0] {
    IDLE,
    INPUT,
    BUILD,
    DECODE
  } state_t;

  state_t state, state_nxt;

  logic [3:0] id  [8];
  logic [5:0] wt  [8];
  logic [3:0] lft [1:7];
  logic [3:0] rgt [1:7];
  logic [3:0] cnt;
  logic [2:0] mcnt;
  logic [2:0] cur;
  logic [2:0] chars;

  logic [2:0] m1, m2;
  logic [9:0] k1, k2;
  logic [3:0] new_id;
  logic [5:0] new_wt;
  logic [3:0] nxt;
  logic       take, leaf, last_char, last_merge;

  assign take       = (state == DECODE) && ready && code_valid;
  assign nxt        = code_in ? rgt[cur] : lft[cur];
  assign leaf       = nxt[3];
  assign last_char  = chars == 3'(NUM_CHAR - 1);
  assign last_merge = mcnt == 3'd6;
  assign new_id     = 4'd7 - {1'b0, mcnt};
  assign new_wt     = wt[m1] + wt[m2];

  // Pick the two lightest live slots, ordering by {weight, id}.
  always_comb begin
    m1 = '0;
    k1 = '1;
    for (int i = 0; i < 8; i++) begin
      if (id[i] != 4'd0 && {wt[i], id[i]} < k1) begin
        k1 = {wt[i], id[i]};
        m1 = 3'(i);
      end
    end
    m2 = '0;
    k2 = '1;
    for (int i = 0; i < 8; i++) begin
      if (3'(i) != m1 && id[i] != 4'd0 &&
          {wt[i], id[i]} < k2) begin
        k2 = {wt[i], id[i]};
        m2 = 3'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (in_valid)   state_nxt = INPUT;
      INPUT:  if (!in_valid)  state_nxt = BUILD;
      BUILD:  if (last_merge) state_nxt = DECODE;
      DECODE: if (take && leaf && last_char)
                state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Weight capture, one merge per BUILD cycle, tree walk in DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        id[i] <= 4'd0;
        wt[i] <= 6'd63;
      end
      for (int i = 1; i < 8; i++) begin
        lft[i] <= 4'd0;
        rgt[i] <= 4'd0;
      end
      cnt       <= 4'd0;
      mcnt      <= 3'd0;
      cur       <= 3'd1;
      chars     <= 3'd0;
      ready     <= 1'b0;
      out_valid <= 1'b0;
      out_char  <= 3'd0;
    end else begin
      out_valid <= 1'b0;
      out_char  <= 3'd0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            id[0] <= 4'd15;
            wt[0] <= {3'b000, in_weight};
            cnt   <= 4'd1;
          end
        end
        INPUT: begin
          if (in_valid && !cnt[3]) begin
            id[cnt[2:0]] <= 4'd15 - cnt;
            wt[cnt[2:0]] <= {3'b000, in_weight};
            cnt          <= cnt + 4'd1;
          end
        end
        BUILD: begin
          id[m1] <= new_id;
          wt[m1] <= new_wt;
          id[m2] <= 4'd0;
          wt[m2] <= 6'd63;
          lft[new_id[2:0]] <= id[m2];
          rgt[new_id[2:0]] <= id[m1];
          mcnt <= mcnt + 3'd1;
          if (last_merge) begin
            mcnt  <= 3'd0;
            ready <= 1'b1;
            cur   <= 3'd1;
          end
        end
        DECODE: begin
          if (take) begin
            if (leaf) begin
              out_valid <= 1'b1;
              // leaf ids 8..15 map to index 15-id
              out_char  <= ~nxt[2:0];
              cur       <= 3'd1;
              chars     <= chars + 3'd1;
              if (last_char) begin
                ready <= 1'b0;
                chars <= 3'd0;
                cnt   <= 4'd0;
                for (int i = 0; i < 8; i++) begin
                  id[i] <= 4'd0;
                  wt[i] <= 6'd63;
                end
                for (int i = 1; i < 8; i++) begin
                  lft[i] <= 4'd0;
                  rgt[i] <= 4'd0;
                end
              end
            end else begin
              cur <= nxt[2:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ht_decoder.sv
// tb_ht_decoder: random frames against a code-table model of the
// Huffman decoder, plus literal pins for the equal-weight and skewed trees.
module tb_ht_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_weight = 3'd0;
  logic       code_valid = 1'b0;
  logic       code_in = 1'b0;
  logic       ready;
  logic       out_valid;
  logic [2:0] out_char;

  int checks = 0;
  int errors = 0;

  ht_decoder #(.NUM_CHAR(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_weight(in_weight),
    .code_valid(code_valid),
    .code_in(code_in),
    .ready(ready),
    .out_valid(out_valid),
    .out_char(out_char)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int code_v[8];
  int code_l[8];
  int mw[8];
  int mn = 0;
  int mphase = 0;
  int mcd = 0;
  int macc = 0;
  int malen = 0;
  int mchars = 0;
  bit exp_ready = 1'b0;
  bit exp_ov = 1'b0;
  int exp_char = 0;

  // Huffman build over abstract node records; codes grow root-ward.
  task automatic build_model();
    int nw[16];
    int mem[16];
    bit live[16];
    int a, b, nid;
    for (int n = 0; n < 16; n++) begin
      live[n] = 1'b0;
      nw[n] = 0;
      mem[n] = 0;
    end
    for (int c = 0; c < 8; c++) begin
      code_v[c] = 0;
      code_l[c] = 0;
      nw[15 - c] = mw[c];
      mem[15 - c] = 1 << c;
      live[15 - c] = 1'b1;
    end
    for (int k = 0; k < 7; k++) begin
      a = -1;
      b = -1;
      for (int n = 1; n < 16; n++)
        if (live[n] && (a < 0 || nw[n] < nw[a])) a = n;
      for (int n = 1; n < 16; n++)
        if (live[n] && n != a && (b < 0 || nw[n] < nw[b])) b = n;
      for (int c = 0; c < 8; c++) begin
        if (mem[a][c]) begin
          code_v[c] = code_v[c] | (1 << code_l[c]);
          code_l[c]++;
        end else if (mem[b][c]) begin
          code_l[c]++;
        end
      end
      nid = 7 - k;
      nw[nid] = nw[a] + nw[b];
      mem[nid] = mem[a] | mem[b];
      live[a] = 1'b0;
      live[b] = 1'b0;
      live[nid] = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mphase = 0;
      mn = 0;
      macc = 0;
      malen = 0;
      mchars = 0;
      exp_ready = 1'b0;
      exp_ov = 1'b0;
      exp_char = 0;
    end else begin
      exp_ov = 1'b0;
      exp_char = 0;
      case (mphase)
        0: if (in_valid) begin
          mw[0] = int'(in_weight);
          mn = 1;
          mphase = 1;
        end
        1: if (in_valid) begin
          if (mn < 8) mw[mn] = int'(in_weight);
          mn++;
        end else begin
          build_model();
          mcd = 7;
          mphase = 2;
        end
        2: begin
          mcd--;
          if (mcd == 0) begin
            exp_ready = 1'b1;
            mphase = 3;
          end
        end
        default: if (code_valid) begin
          macc = macc * 2 + int'(code_in);
          malen++;
          for (int c = 0; c < 8; c++)
            if (code_l[c] == malen && code_v[c] == macc) begin
              exp_ov = 1'b1;
              exp_char = c;
            end
          if (exp_ov) begin
            macc = 0;
            malen = 0;
            mchars++;
            if (mchars == 5) begin
              mchars = 0;
              exp_ready = 1'b0;
              mphase = 0;
            end
          end
        end
      endcase
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("ready", int'(ready), int'(exp_ready));
    chk("out_valid", int'(out_valid), int'(exp_ov));
    chk("out_char", int'(out_char), exp_char);
  end

  int got[$];
  initial forever begin
    @(negedge clk);
    if (out_valid) got.push_back(int'(out_char));
  end

  // ---------------- stimulus ----------------
  bit bq[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_weights(input int w[8], input bit early,
                              output int lat);
    for (int i = 0; i < 8; i++) begin
      step();
      in_valid = 1'b1;
      in_weight = 3'(w[i]);
      code_valid = 1'b0;
    end
    step();
    in_valid = 1'b0;
    in_weight = 3'd0;
    code_valid = early;
    code_in = early;
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      if (ready) break;
      lat++;
      if (lat == 5) begin
        code_valid = 1'b0;
        code_in = 1'b0;
      end
    end
    code_valid = 1'b0;
    code_in = 1'b0;
  endtask

  task automatic send_bits(input int gap_at, input int gap_len,
                           input bit rnd);
    for (int i = 0; i < bq.size(); i++) begin
      if (i == gap_at)
        for (int g = 0; g < gap_len; g++) begin
          step();
          code_valid = 1'b0;
          code_in = 1'($urandom_range(1, 0));
        end
      if (rnd && $urandom_range(3, 0) == 0) begin
        step();
        code_valid = 1'b0;
        code_in = 1'($urandom_range(1, 0));
      end
      step();
      code_valid = 1'b1;
      code_in = bq[i];
    end
  endtask

  task automatic finish_bits();
    step();
    code_valid = 1'b0;
    code_in = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic enc(input int ch[5], input int n);
    bq.delete();
    for (int i = 0; i < n; i++)
      for (int k = code_l[ch[i]] - 1; k >= 0; k--)
        bq.push_back(code_v[ch[i]][k]);
  endtask

  task automatic check_got(input string nm, input int ch[5]);
    chk({nm, "_count"}, got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      chk(nm, got[i], ch[i]);
    got.delete();
  endtask

  task automatic rand_frame(output int w[8], output int ch[5]);
    for (int i = 0; i < 8; i++) w[i] = int'($urandom_range(7, 1));
    for (int i = 0; i < 5; i++) ch[i] = int'($urandom_range(7, 0));
  endtask

  int w[8];
  int ch[5];
  int lat;
  int nb;
  int eq_codes[8] = '{2, 3, 0, 1, 6, 7, 4, 5};
  int ilove[5] = '{4, 5, 6, 7, 3};
  logic [14:0] ilove_bits = 15'b110_111_100_101_001;

  initial begin
    #2;
    chk("reset_ready", int'(ready), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_char", int'(out_char), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Equal-weight tree, early bits during BUILD.
    for (int i = 0; i < 8; i++) w[i] = 1;
    send_weights(w, 1'b1, lat);
    chk("eq_ready_latency", lat, 8);
    for (int c = 0; c < 8; c++) begin
      chk("eq_code_len", code_l[c], 3);
      chk("eq_code", code_v[c], eq_codes[c]);
    end

    // ILOVE, continuous.
    bq.delete();
    for (int i = 14; i >= 0; i--) bq.push_back(ilove_bits[i]);
    send_bits(-1, 0, 1'b0);
    finish_bits();
    check_got("ilove", ilove);
    chk("ilove_ready_drop", int'(ready), 0);

    // Same stream, 3-cycle gap inside the O codeword.
    send_weights(w, 1'b0, lat);
    chk("gap_ready_latency", lat, 8);
    send_bits(7, 3, 1'b0);
    finish_bits();
    check_got("gapped", ilove);

    // Skewed weights, then a back-to-back random frame.
    w[0] = 7;
    send_weights(w, 1'b1, lat);
    chk("skew_ready_latency", lat, 8);
    chk("skew_a_len", code_l[0], 1);
    chk("skew_a_code", code_v[0], 0);
    chk("skew_b_len", code_l[1], 3);
    ch[0] = 0;
    for (int i = 1; i < 5; i++) ch[i] = int'($urandom_range(7, 0));
    enc(ch, 5);
    send_bits(-1, 0, 1'b1);
    rand_frame(w, ch);
    begin
      int ch_prev[5];
      ch_prev[0] = 0;
      for (int i = 1; i < 5; i++) ch_prev[i] = ch[i];
    end
    send_weights(w, 1'b0, lat);
    chk("b2b_ready_latency", lat, 8);
    chk("skew_frame_count", got.size(), 5);
    if (got.size() > 0) chk("skew_first_a", got[0], 0);
    got.delete();
    enc(ch, 5);
    send_bits(-1, 0, 1'b1);
    finish_bits();
    check_got("b2b", ch);

    // Reset after two characters of a random frame.
    rand_frame(w, ch);
    send_weights(w, 1'b0, lat);
    enc(ch, 5);
    nb = code_l[ch[0]] + code_l[ch[1]] + 1;
    while (bq.size() > nb) void'(bq.pop_back());
    send_bits(-1, 0, 1'b0);
    finish_bits();
    chk("pre_reset_count", got.size(), 2);
    got.delete();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", int'(ready), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_char", int'(out_char), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    rand_frame(w, ch);
    send_weights(w, 1'b1, lat);
    chk("post_reset_latency", lat, 8);
    enc(ch, 5);
    send_bits(-1, 0, 1'b1);
    finish_bits();
    check_got("post_reset", ch);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
